full_adder_bist: RTL and testbench
==================================

# full_adder_bist

Built-in self-test engine for the single-bit `full_adder`. On a `start` pulse it drives all eight input combinations into an attached adder in truth-table order, waits a programmable settle time, and compares `Sum`/`Cout` against a golden model. It accumulates an error count and a per-vector fail mask, then reports pass/fail. It sits beside the adder under test and replaces the simulation-only exhaustive stimulus with a synthesizable checker end.

## Interface
- `SETTLE_CYCLES`, default 1: clock cycles each vector is held before the response is sampled; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to run the test; honoured only in IDLE or DONE.
- `fa_sum`  in  1  `Sum` returned by the adder under test.
- `fa_cout`  in  1  `Cout` returned by the adder under test.
- `fa_a`, `fa_b`, `fa_cin`  out  1 each  registered stimulus driven to the adder under test.
- `busy`  out  1  high while a run is in progress (states SETTLE and CHECK).
- `done`  out  1  high in DONE; held until the next `start` or reset.
- `pass`  out  1  valid while `done`=1; equals 1 exactly when `err_cnt`=0.
- `err_cnt`  out  4  number of mismatching vectors, 0..8.
- `fail_mask`  out  8  bit *i* is set when vector *i* mismatched.

## Operation
- Vector index `idx` runs 0..7. Stimulus mapping: `fa_a`=`idx[2]`, `fa_b`=`idx[1]`, `fa_cin`=`idx[0]`.
- Expected results: sum = `a^b^cin`; cout = majority(`a`, `b`, `cin`).
- A vector mismatches if either `fa_sum` or `fa_cout` differs from the expected value.
- States:
  - IDLE: outputs hold reset values. On `start`=1, clear `err_cnt` and `fail_mask`, set `idx`=0, load vector 0 into `fa_*`, load the settle counter with `SETTLE_CYCLES`, go to SETTLE.
  - SETTLE: decrement the settle counter. Go to CHECK when the counter equals 1.
  - CHECK: sample `fa_sum` and `fa_cout`. On mismatch, increment `err_cnt` and set `fail_mask[idx]`.
    - If `idx`<7: increment `idx`, load the next vector into `fa_*`, reload the settle counter, go to SETTLE.
    - If `idx`=7: go to DONE. `fa_*` hold the last vector.
  - DONE: `done`=1; `pass`=(`err_cnt`==0). On `start`=1, perform the same actions as `start` from IDLE, which restarts the run.
- `start` while `busy`=1 is ignored; there is no abort.
- Reset values (from any state, including mid-run): state IDLE, `idx`=0, `fa_a`/`fa_b`/`fa_cin`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_mask`=0.
- `err_cnt` cannot exceed 8, so it never saturates or wraps.

## Timing
- Each vector occupies `SETTLE_CYCLES`+1 cycles: `SETTLE_CYCLES` in SETTLE, then 1 in CHECK.
- With the `start` edge at cycle 0, vector *i* is driven from cycle *i*·(S+1)+1, where S = `SETTLE_CYCLES`.
- Its response is sampled at the edge ending its CHECK cycle.
- `done` rises at cycle 8·(S+1)+1. With the default S=1, `done` rises at cycle 17.
- `busy` is high for exactly 8·(S+1) cycles.
- `err_cnt`, `fail_mask` and `pass` are stable whenever `done`=1.
- The adder path must settle within S cycles. The block is sample-and-compare only and performs no asynchronous sampling.

## Structure
- Package `fa_bist_pkg` holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - `NUM_VECTORS`=8;
  - `IDX_W`=3;
  - `ERR_W`=4.
- Sub-module: one instance of the existing `full_adder` as the golden model. Its inputs are `fa_a`/`fa_b`/`fa_cin`, and its outputs are compared against `fa_sum`/`fa_cout`.
- Everything else lives in one FSM plus counters in the top module.

## Test plan
- Correct adder, S=1, pulse `start` → `done` rises at cycle 17; `pass`=1, `err_cnt`=0, `fail_mask`=8'h00; `fa_*` walk 000..111 in order.
- Adder with `Cout` stuck at 0 → `err_cnt`=4, `fail_mask`=8'hE8 (vectors 3, 5, 6, 7), `pass`=0.
- Adder with `Sum` inverted, S=3 → `done` at cycle 33, `err_cnt`=8, `fail_mask`=8'hFF.
- Pulse `start` again at cycle 5 of a run → ignored; `done` still rises at cycle 17. Pulse `start` in DONE → counters clear and `done` drops the next cycle.
- Drive `rst_n`=0 for one cycle mid-run (cycle 9) → next cycle all outputs are zero and the state is IDLE. A subsequent `start` produces a full clean run.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// Shared types and sizing for the full-adder BIST engine.
package fa_bist_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int ERR_W       = 4;
endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; used here as the golden reference for the BIST.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_bist.sv
// Exhaustive self-test of an attached full adder: walks all 8 vectors,
// waits SETTLE_CYCLES per vector, compares against a golden adder.
module full_adder_bist
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       fail_mask
);
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_VECTORS - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0]               settle_q, settle_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic [NUM_VECTORS-1:0]   mask_q, mask_d;
    logic                     gold_sum, gold_cout, mismatch;

    // The stimulus register is idx itself, so fa_* are flop outputs.
    full_adder u_golden (
        .a    (idx_q[2]),
        .b    (idx_q[1]),
        .cin  (idx_q[0]),
        .sum  (gold_sum),
        .cout (gold_cout)
    );

    assign mismatch = (fa_sum != gold_sum) || (fa_cout != gold_cout);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = SETTLE;
                    idx_d    = '0;
                    err_d    = '0;
                    mask_d   = '0;
                    settle_d = SETTLE_LD;
                end
            end
            SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q == 4'd1) state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d         = err_q + ERR_W'(1);
                    mask_d[idx_q] = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    settle_d = SETTLE_LD;
                    state_d  = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            mask_q   <= mask_d;
        end
    end

    assign fa_a      = idx_q[2];
    assign fa_b      = idx_q[1];
    assign fa_cin    = idx_q[0];
    assign busy      = (state_q == SETTLE) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == '0);
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;
endmodule

// File: tb/tb_full_adder_bist.sv
// Scoreboard bench: two BIST instances (S=1, S=3) against fault-injectable adders.
module tb_full_adder_bist;
    typedef struct {
        int         start;
        int         err;
        logic [7:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    logic       rst_s   [2];
    logic       start_s [2];
    logic       fsum    [2];
    logic       fcout   [2];
    logic       fa_a    [2];
    logic       fa_b    [2];
    logic       fa_ci   [2];
    logic       o_busy  [2];
    logic       o_done  [2];
    logic       o_pass  [2];
    logic [3:0] o_err   [2];
    logic [7:0] o_mask  [2];
    logic       stuck_c [2];
    logic [7:0] flip_s  [2];
    logic [7:0] flip_c  [2];
    logic       chk_zero[2];
    logic       chk_drop[2];
    logic       prev_done[2];
    int         bc      [2];
    exp_t       exp_q   [2][$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2:0] v;
        assign v = {fa_a[g], fa_b[g], fa_ci[g]};
        // Adder under test with per-vector injectable faults.
        assign fsum[g]  = (fa_a[g] ^ fa_b[g] ^ fa_ci[g]) ^ flip_s[g][v];
        assign fcout[g] = stuck_c[g] ? 1'b0 :
                          (((fa_a[g] & fa_b[g]) | (fa_a[g] & fa_ci[g]) | (fa_b[g] & fa_ci[g])) ^ flip_c[g][v]);

        full_adder_bist #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst_n     (rst_s[g]),
            .start     (start_s[g]),
            .fa_sum    (fsum[g]),
            .fa_cout   (fcout[g]),
            .fa_a      (fa_a[g]),
            .fa_b      (fa_b[g]),
            .fa_cin    (fa_ci[g]),
            .busy      (o_busy[g]),
            .done      (o_done[g]),
            .pass      (o_pass[g]),
            .err_cnt   (o_err[g]),
            .fail_mask (o_mask[g])
        );
    end

    function automatic int s_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference: arithmetic add of three bits versus what the faulty adder returns.
    function automatic exp_t model(input int d);
        exp_t e;
        e.start = cyc;
        e.err   = 0;
        e.mask  = '0;
        for (int vv = 0; vv < 8; vv++) begin
            int a, b, c, tot, rs, rc, ds, dc;
            a = (vv >> 2) & 1; b = (vv >> 1) & 1; c = vv & 1;
            tot = a + b + c;
            rs = tot % 2;
            rc = tot / 2;
            ds = rs ^ int'(flip_s[d][vv]);
            dc = stuck_c[d] ? 0 : (rc ^ int'(flip_c[d][vv]));
            if (ds != rs || dc != rc) begin
                e.mask[vv] = 1'b1;
                e.err++;
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input int d, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, want %0d (cycle %0d)", name, d, act, req, cyc);
        end
    endtask

    // Monitor: all comparisons live here, decoupled from stimulus.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_s[d]) begin
                exp_q[d].delete();
                bc[d] = 0;
                prev_done[d] = 1'b0;
            end else begin
                if (chk_zero[d]) begin
                    chk("rst_busy", d, int'(o_busy[d]), 0);
                    chk("rst_done", d, int'(o_done[d]), 0);
                    chk("rst_pass", d, int'(o_pass[d]), 0);
                    chk("rst_err", d, int'(o_err[d]), 0);
                    chk("rst_mask", d, int'(o_mask[d]), 0);
                    chk("rst_vec", d, int'({fa_a[d], fa_b[d], fa_ci[d]}), 0);
                end
                if (chk_drop[d]) begin
                    chk("restart_done", d, int'(o_done[d]), 0);
                    chk("restart_err", d, int'(o_err[d]), 0);
                    chk("restart_mask", d, int'(o_mask[d]), 0);
                end
                if (o_busy[d]) begin
                    bc[d]++;
                    if (exp_q[d].size() != 0)
                        chk("walk_vec", d, int'({fa_a[d], fa_b[d], fa_ci[d]}),
                            (cyc - exp_q[d][0].start - 1) / (s_of(d) + 1));
                end
                if (o_done[d] && !prev_done[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("unexpected_done", d, 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        chk("done_cycle", d, cyc - e.start, 8 * (s_of(d) + 1) + 1);
                        chk("err_cnt", d, int'(o_err[d]), e.err);
                        chk("fail_mask", d, int'(o_mask[d]), int'(e.mask));
                        chk("pass", d, int'(o_pass[d]), (e.err == 0) ? 1 : 0);
                        chk("last_vec", d, int'({fa_a[d], fa_b[d], fa_ci[d]}), 7);
                        chk("busy_len", d, bc[d], 8 * (s_of(d) + 1));
                    end
                    bc[d] = 0;
                end else if (exp_q[d].size() != 0 &&
                             cyc - exp_q[d][0].start > 8 * (s_of(d) + 1) + 4) begin
                    chk("done_timeout", d, 0, 1);
                    void'(exp_q[d].pop_front());
                end
                prev_done[d] = o_done[d];
            end
        end
    end

    task automatic set_cfg(input int d, input logic st, input logic [7:0] fs, input logic [7:0] fc);
        stuck_c[d] = st;
        flip_s[d]  = fs;
        flip_c[d]  = fc;
    endtask

    // Returns one ns into cycle 1 of the (possibly ignored) request.
    task automatic pulse(input int d, input bit push);
        start_s[d] = 1'b1;
        if (push) exp_q[d].push_back(model(d));
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 300 && exp_q[d].size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b0; start_s[d] = 1'b0;
            chk_zero[d] = 1'b0; chk_drop[d] = 1'b0;
            prev_done[d] = 1'b0; bc[d] = 0;
            set_cfg(d, 1'b0, 8'h00, 8'h00);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin rst_s[d] = 1'b1; chk_zero[d] = 1'b1; end
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) chk_zero[d] = 1'b0;
        @(posedge clk); #1;

        // S=1: clean, then Cout stuck at 0, then restart from DONE.
        pulse(0, 1); wait_done(0);
        set_cfg(0, 1'b1, 8'h00, 8'h00);
        pulse(0, 1); wait_done(0);
        set_cfg(0, 1'b0, 8'h00, 8'h00);
        pulse(0, 1);
        chk_drop[0] = 1'b1;
        @(negedge clk); #1;
        chk_drop[0] = 1'b0;
        wait_done(0);

        // start at cycle 5 of a run is ignored
        pulse(0, 1);
        repeat (4) @(posedge clk);
        #1;
        pulse(0, 0);
        wait_done(0);

        // one-cycle reset at cycle 9, then a clean run
        set_cfg(0, 1'b0, 8'h14, 8'h00);
        pulse(0, 1);
        repeat (8) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_s[0] = 1'b1;
        chk_zero[0] = 1'b1;
        @(negedge clk); #1;
        chk_zero[0] = 1'b0;
        set_cfg(0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        pulse(0, 1); wait_done(0);

        // S=3: Sum inverted on every vector.
        set_cfg(1, 1'b0, 8'hFF, 8'h00);
        pulse(1, 1); wait_done(1);

        // Random fault patterns on both instances.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 2; d++) begin
                set_cfg(d, 1'($urandom_range(0, 3) == 0),
                        8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                pulse(d, 1); wait_done(d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
